fetch_unit: RTL and testbench

Instruction fetch stage for the 19-bit CPU. Holds the program counter and issues word reads to instruction memory over a req/ack handshake. It latches each returned word into an instruction register and presents it, split into fields, to the decode/control stage over a valid/ready handshake. Sits directly upstream of the opcode decoder, driving its 5-bit opcode input, and accepts PC redirects from execute.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit CPU: instruction field layout, the HALT
// opcode and the fetch-stage state encoding.
package cpu_pkg;

    localparam int INSTR_W  = 19;
    localparam int OPCODE_W = 5;
    localparam int REG_W    = 3;
    localparam int IMM_W    = 5;

    localparam int OPCODE_LSB = 14;
    localparam int RD_LSB     = 11;
    localparam int RS1_LSB    = 8;
    localparam int RS2_LSB    = 5;
    localparam int IMM_LSB    = 0;

    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_REQ,
        FS_HOLD,
        FS_DRAIN,
        FS_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack sequencing and the instruction
// register presented to decode over valid/ready.
//
// state    | meaning
// FS_IDLE  | out of reset, no request yet
// FS_REQ   | imem_req high at r_addr (== pc), waiting for ack
// FS_HOLD  | instruction held in r_ir, out_valid high until accepted
// FS_DRAIN | redirected while a read was outstanding; wait for its ack
// FS_HALT  | HALT accepted, fetch stopped until a redirect
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    rs1,
    output logic [REG_W-1:0]    rs2,
    output logic [IMM_W-1:0]    imm5,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                halted
);

    fetch_state_t         r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_req;
    logic                 r_valid;
    logic                 r_halted;
    logic [INSTR_W-1:0]   r_ir;
    logic [ADDR_W-1:0]    r_instr_pc;
    logic                 w_is_halt;

    assign w_is_halt = (r_ir[OPCODE_LSB +: OPCODE_W] == OP_HALT);

    // r_addr is separate from r_pc so a redirect during DRAIN can move the PC
    // while the outstanding request keeps its original address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FS_IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_ir       <= '0;
            r_instr_pc <= '0;
        end else begin
            case (r_state)
                FS_IDLE: begin
                    r_state <= FS_REQ;
                    r_req   <= 1'b1;
                    if (redirect_valid) begin
                        r_pc   <= redirect_pc;
                        r_addr <= redirect_pc;
                    end else begin
                        r_addr <= r_pc;
                    end
                end
                FS_REQ: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                        if (imem_ack) begin
                            r_addr <= redirect_pc;
                        end else begin
                            r_state <= FS_DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_instr_pc <= r_addr;
                        r_pc       <= r_pc + ADDR_W'(1);
                        r_req      <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (redirect_valid) begin
                        r_pc    <= redirect_pc;
                        r_addr  <= redirect_pc;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= FS_REQ;
                    end else if (out_ready) begin
                        r_valid <= 1'b0;
                        if (w_is_halt) begin
                            r_halted <= 1'b1;
                            r_state  <= FS_HALT;
                        end else begin
                            r_addr  <= r_pc;
                            r_req   <= 1'b1;
                            r_state <= FS_REQ;
                        end
                    end
                end
                FS_DRAIN: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end
                    if (imem_ack) begin
                        r_addr  <= redirect_valid ? redirect_pc : r_pc;
                        r_state <= FS_REQ;
                    end
                end
                FS_HALT: begin
                    if (redirect_valid) begin
                        r_pc     <= redirect_pc;
                        r_addr   <= redirect_pc;
                        r_req    <= 1'b1;
                        r_halted <= 1'b0;
                        r_state  <= FS_REQ;
                    end
                end
                default: begin
                    r_state <= FS_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign out_valid = r_valid;
    assign instr     = r_ir;
    assign opcode    = r_ir[OPCODE_LSB +: OPCODE_W];
    assign rd        = r_ir[RD_LSB +: REG_W];
    assign rs1       = r_ir[RS1_LSB +: REG_W];
    assign rs2       = r_ir[RS2_LSB +: REG_W];
    assign imm5      = r_ir[IMM_LSB +: IMM_W];
    assign instr_pc  = r_instr_pc;
    assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected words,
// a monitor pops them on each accepted instruction.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [18:0] imem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] instr;
    logic [4:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [4:0]  imm5;
    logic [7:0]  instr_pc;
    logic        halted;

    typedef struct packed {
        logic [18:0] w;
        logic [7:0]  pc;
    } exp_t;

    exp_t        sbq[$];
    logic [18:0] mem[256];
    int          lat;
    int          mcnt;
    int          n_vec  = 0;
    int          n_miss = 0;

    fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm5(imm5), .instr_pc(instr_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory: ack after `lat` wait cycles; junk data when not acking.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 19'h7FFFF;
        mcnt       = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !imem_req) begin
                imem_ack   = 1'b0;
                imem_rdata = 19'h7FFFF;
                mcnt       = 0;
            end else if (mcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr];
                mcnt       = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 19'h7FFFF;
                mcnt++;
            end
        end
    end

    // Monitor, sampled one unit before each rising edge.
    initial begin
        logic       prev_req;
        logic       prev_ack;
        logic [7:0] prev_addr;
        exp_t       e;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (prev_req && !prev_ack)
                    chk("req_held", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, prev_addr});
                if (out_valid && out_ready && !redirect_valid) begin
                    if (sbq.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_out: got instr_pc %0h expected no output", instr_pc);
                    end else begin
                        e = sbq.pop_front();
                        chk("instr", {13'd0, instr}, {13'd0, e.w});
                        chk("instr_pc", {24'd0, instr_pc}, {24'd0, e.pc});
                        chk("fields", {13'd0, opcode, rd, rs1, rs2, imm5}, {13'd0, e.w});
                    end
                end
                prev_req  = imem_req;
                prev_ack  = imem_ack;
                prev_addr = imem_addr;
            end
        end
    end

    task automatic fetch_accept(input logic [7:0] a);
        int k;
        sbq.push_back({mem[a], a});
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout_valid: got out_valid 0 expected 1 for pc %0h", a);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic redir(input logic [7:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_instr"}, {13'd0, instr}, 32'd0);
        chk({tag, "_ipc"}, {24'd0, instr_pc}, 32'd0);
        chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    initial begin
        logic seen;
        int   k;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {2'b00, i[2:0], i[7:0] ^ 8'hA5, 6'(i * 3)};
        end
        mem[8'h00] = 19'h04A21;
        mem[8'h50] = {5'h1F, 14'h0123};
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        lat            = 0;

        // Reset, then zero-wait fetch of word 0.
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rst0");
        rst_n = 1'b1;
        @(negedge clk);
        chk("c1_req", {31'd0, imem_req}, 32'd1);
        chk("c1_addr", {24'd0, imem_addr}, 32'd0);
        chk("c1_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("c2_valid", {31'd0, out_valid}, 32'd1);
        chk("c2_opcode", {27'd0, opcode}, 32'd1);
        chk("c2_rd", {29'd0, rd}, 32'd1);
        chk("c2_rs1", {29'd0, rs1}, 32'd2);
        chk("c2_rs2", {29'd0, rs2}, 32'd1);
        chk("c2_imm5", {27'd0, imm5}, 32'd1);
        chk("c2_ipc", {24'd0, instr_pc}, 32'd0);
        chk("c2_req", {31'd0, imem_req}, 32'd0);

        // Streaming at one instruction per two cycles.
        for (int i = 0; i < 5; i++) sbq.push_back({mem[i], 8'(i)});
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        chk("stream_drained", sbq.size(), 32'd0);
        chk("stream_next_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_next_ipc", {24'd0, instr_pc}, 32'd5);

        // Three wait cycles, decode stalls four cycles.
        lat = 3;
        fetch_accept(8'h05);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("slow_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_instr", {13'd0, instr}, {13'd0, mem[6]});
            chk("stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        fetch_accept(8'h06);
        chk("pc_inc_req", {31'd0, imem_req}, 32'd1);
        chk("pc_inc_addr", {24'd0, imem_addr}, 32'd7);

        // Redirect while a read is outstanding: drain, never present old data.
        redir(8'h40);
        chk("drain_req", {31'd0, imem_req}, 32'd1);
        chk("drain_addr", {24'd0, imem_addr}, 32'd7);
        seen = 1'b0;
        k = 0;
        while (imem_addr != 8'h40 && k < 20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            k++;
        end
        chk("drain_new_addr", {24'd0, imem_addr}, 32'h40);
        chk("drain_new_req", {31'd0, imem_req}, 32'd1);
        chk("drain_no_valid", {31'd0, seen}, 32'd0);
        fetch_accept(8'h40);

        // Redirect in HOLD with out_ready high drops the held word.
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        lat            = 0;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        @(negedge clk);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        chk("hold_redir_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_redir_addr", {24'd0, imem_addr}, 32'h20);
        chk("hold_redir_req", {31'd0, imem_req}, 32'd1);
        fetch_accept(8'h20);

        // Redirect coinciding with a zero-wait ack discards the data.
        redir(8'h30);
        chk("ackredir_valid", {31'd0, out_valid}, 32'd0);
        chk("ackredir_addr", {24'd0, imem_addr}, 32'h30);
        fetch_accept(8'h30);

        // PC wrap.
        redir(8'hFF);
        fetch_accept(8'hFF);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        chk("wrap_addr", {24'd0, imem_addr}, 32'd0);
        fetch_accept(8'h00);

        // HALT, idle for 20 cycles, then redirect out.
        redir(8'h50);
        fetch_accept(8'h50);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, out_valid}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req) seen = 1'b1;
        end
        chk("halt_noreq", {31'd0, seen}, 32'd0);
        chk("halt_still", {31'd0, halted}, 32'd1);
        lat = 3;
        redir(8'h10);
        chk("unhalt_flag", {31'd0, halted}, 32'd0);
        chk("unhalt_req", {31'd0, imem_req}, 32'd1);
        chk("unhalt_addr", {24'd0, imem_addr}, 32'h10);

        // Asynchronous reset in the middle of a memory wait.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        @(negedge clk);
        lat   = 0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerst_req", {31'd0, imem_req}, 32'd1);
        chk("rerst_addr", {24'd0, imem_addr}, 32'd0);
        fetch_accept(8'h00);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
